// File: rtl/forward_tracker.sv
// Operand-forwarding select and load-use hazard detection for the EX stage.
// Tracks the destination registers of the writers between EX and writeback.
module forward_tracker #(
    parameter  int NUM_SRC    = 2,
    parameter  int DEPTH      = 2,
    parameter  int LOAD_STAGE = 2,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hold_i,
    input  logic                     flush_i,
    input  logic                     ex_valid_i,
    input  logic [4:0]               ex_rd_i,
    input  logic                     ex_regwrite_i,
    input  logic                     ex_memread_i,
    input  logic [NUM_SRC*5-1:0]     ex_rs_i,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic                     hazard_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
        logic       ld;
    } slot_t;

    // Slot 1 is the youngest writer (EX/MEM), slot DEPTH the oldest.
    slot_t              slot_q [1:DEPTH];
    slot_t              ex_entry;
    logic [NUM_SRC-1:0] port_hz;

    assign ex_entry = '{wr: ex_valid_i & ex_regwrite_i,
                        rd: ex_rd_i,
                        ld: ex_valid_i & ex_memread_i};

    // NOTE: every output of this block is defaulted before the search loop so no latch is inferred.
    always_comb begin
        fwd_sel_o = '0;
        port_hz   = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            // Scan oldest to youngest so the youngest matching slot is written last and wins.
            for (int k = DEPTH; k >= 1; k--) begin
                if (slot_q[k].wr && (slot_q[k].rd != 5'd0) &&
                    (slot_q[k].rd == ex_rs_i[5*p +: 5])) begin
                    fwd_sel_o[SEL_W*p +: SEL_W] = SEL_W'(k);
                    port_hz[p]                  = slot_q[k].ld && (k < LOAD_STAGE);
                end
            end
        end
    end

    assign hazard_o = (|port_hz) & ~hold_i;

    // NOTE: state updates use non-blocking assignments so the slot shift reads pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the slots are a handful of flops, not a RAM, so clearing all of them is cheap and required.
            for (int k = 1; k <= DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            stall_cnt_o <= '0;
        end else if (!hold_i) begin
            for (int k = DEPTH; k >= 2; k--) begin
                slot_q[k] <= slot_q[k-1];
            end
            slot_q[1] <= (hazard_o || flush_i) ? slot_t'('0) : ex_entry;
            if (hazard_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_forward_tracker.sv
// Scenario bench for forward_tracker: directed tables plus a randomized run
// against a small reference model, with a queue of expected outputs per cycle.
module tb_forward_tracker;

    typedef struct {
        logic        rst, hold, flush, v, rw, mr;
        logic [4:0]  rd, rs0, rs1;
        logic [3:0]  sel;
        logic        hz;
        logic [15:0] cnt;
    } row_t;

    typedef struct {
        logic [3:0]  sel;
        logic        hz;
        logic [15:0] cnt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i, hold_i, flush_i, ex_valid_i, ex_regwrite_i, ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic [9:0]  ex_rs_i;
    logic [3:0]  fwd_sel, s_fwd_sel;
    logic        hazard, s_hazard;
    logic [15:0] stall_cnt;
    logic [1:0]  s_stall_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    forward_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_rs_i(ex_rs_i),
        .fwd_sel_o(fwd_sel), .hazard_o(hazard), .stall_cnt_o(stall_cnt)
    );

    forward_tracker #(.CNT_W(2)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_rs_i(ex_rs_i),
        .fwd_sel_o(s_fwd_sel), .hazard_o(s_hazard), .stall_cnt_o(s_stall_cnt)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

    function automatic row_t mk(input logic rst, hold, flush, v, rw, mr,
                                input logic [4:0] rd, rs0, rs1,
                                input logic [3:0] sel, input logic hz,
                                input logic [15:0] cnt);
        row_t r;
        r.rst = rst; r.hold = hold; r.flush = flush; r.v = v; r.rw = rw; r.mr = mr;
        r.rd = rd; r.rs0 = rs0; r.rs1 = rs1; r.sel = sel; r.hz = hz; r.cnt = cnt;
        return r;
    endfunction

    // Drives one cycle of stimulus and queues the outputs that cycle must show.
    task automatic drive_row(input row_t r);
        rst_i         = r.rst;
        hold_i        = r.hold;
        flush_i       = r.flush;
        ex_valid_i    = r.v;
        ex_regwrite_i = r.rw;
        ex_memread_i  = r.mr;
        ex_rd_i       = r.rd;
        ex_rs_i       = {r.rs1, r.rs0};
        sb.push_back('{sel: r.sel, hz: r.hz, cnt: r.cnt});
    endtask

    task automatic do_reset();
        drive_row(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(sb.pop_front());
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 1, 1, 0, 5, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(1, 1, 1, 1, 1, 0, 5, 5, 5, 4'b0101, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 5, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 1, 1, 7, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0100, 1, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 0, 0));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL reset[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_priority();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 1, 1, 0, 5, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 1, 0, 5, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 5, 4'b0101, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 4'b0010, 0, 0));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL priority[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_x0();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 6, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 4'b0000, 0, 0));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL x0[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_load_use();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 1, 1, 1, 7, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 1, 0, 8, 0, 7, 4'b0100, 1, 0));
        t.push_back(mk(0, 0, 0, 1, 1, 0, 8, 8, 7, 4'b1000, 0, 1));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 0, 4'b0001, 0, 1));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL load_use[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_hold();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 1, 1, 0, 3, 0, 0, 4'b0000, 0, 0));
        for (int i = 0; i < 3; i++) t.push_back(mk(0, 1, 0, 1, 1, 1, 4, 3, 0, 4'b0001, 0, 0));
        t.push_back(mk(0, 0, 0, 1, 1, 1, 4, 3, 4, 4'b0001, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 4, 4'b0100, 0, 0));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 4, 4'b0100, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 4, 4'b0110, 1, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 4'b1000, 0, 1));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL hold[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_flush();
        row_t t[$];
        exp_t e;
        do_reset();
        t.push_back(mk(0, 0, 0, 1, 1, 0, 10, 0, 0, 4'b0000, 0, 0));
        t.push_back(mk(0, 0, 1, 1, 1, 0, 9, 10, 0, 4'b0001, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 10, 4'b1000, 0, 0));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL flush[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            @(negedge clk_i);
        end
    endtask

    // Runs on the 2-bit-counter instance: five load-use stalls, then reset under hold.
    task automatic test_saturation();
        row_t t[$];
        exp_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            t.push_back(mk(0, 0, 0, 1, 1, 1, 7, 0, 0, 4'b0000, 0, 16'((i > 3) ? 3 : i)));
            t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0100, 1, 16'((i > 3) ? 3 : i)));
        end
        t.push_back(mk(1, 1, 0, 1, 1, 0, 12, 7, 7, 4'b1010, 0, 3));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 7, 4'b0000, 0, 0));
        foreach (t[i]) begin
            drive_row(t[i]);
            #1;
            e = sb.pop_front();
            checks++;
            if ({s_fwd_sel, s_hazard, s_stall_cnt} !== {e.sel, e.hz, e.cnt[1:0]}) begin
                errors++;
                $display("FAIL saturation[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         i, s_fwd_sel, s_hazard, s_stall_cnt, e.sel, e.hz, e.cnt[1:0]);
            end
            @(negedge clk_i);
        end
    endtask

    // Back-to-back random traffic checked against a behavioural model of the slots.
    task automatic test_back_to_back();
        logic       m_wr [1:2];
        logic [4:0] m_rd [1:2];
        logic       m_ld [1:2];
        int         m_cnt;
        row_t       r;
        exp_t       e;
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            m_wr[k] = 1'b0; m_rd[k] = 5'd0; m_ld[k] = 1'b0;
        end
        m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rs;
            int         s;
            logic       h;
            r = mk($urandom_range(0, 99) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   0, 0, 0);
            h = 1'b0;
            for (int p = 0; p < 2; p++) begin
                rs = (p == 0) ? r.rs0 : r.rs1;
                s  = 0;
                for (int k = 1; k <= 2; k++) begin
                    if (s == 0 && m_wr[k] && m_rd[k] != 5'd0 && m_rd[k] == rs) s = k;
                end
                r.sel[2*p +: 2] = 2'(s);
                if (s == 1 && m_ld[1]) h = 1'b1;
            end
            r.hz  = h & ~r.hold;
            r.cnt = 16'(m_cnt);
            drive_row(r);
            #1;
            e = sb.pop_front();
            checks++;
            if ({fwd_sel, hazard, stall_cnt} !== {e.sel, e.hz, e.cnt}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: sel=%b hz=%b cnt=%0d, expected sel=%b hz=%b cnt=%0d",
                         n, fwd_sel, hazard, stall_cnt, e.sel, e.hz, e.cnt);
            end
            if (r.rst) begin
                for (int k = 1; k <= 2; k++) begin
                    m_wr[k] = 1'b0; m_rd[k] = 5'd0; m_ld[k] = 1'b0;
                end
                m_cnt = 0;
            end else if (!r.hold) begin
                if (r.hz && m_cnt < 65535) m_cnt++;
                m_wr[2] = m_wr[1]; m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
                if (r.hz || r.flush) begin
                    m_wr[1] = 1'b0; m_rd[1] = 5'd0; m_ld[1] = 1'b0;
                end else begin
                    m_wr[1] = r.v & r.rw; m_rd[1] = r.rd; m_ld[1] = r.v & r.mr;
                end
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0;
        ex_regwrite_i = 1'b0; ex_memread_i = 1'b0; ex_rd_i = '0; ex_rs_i = '0;
        @(negedge clk_i);
        test_reset();
        test_priority();
        test_x0();
        test_load_use();
        test_hold();
        test_flush();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
